// File: rtl/my_spi_pkg.sv
// Shared constants and the TX byte-start load selection used by the SPI slave.
package my_spi_pkg;

  localparam int SPI_WIDTH   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = $clog2(SPI_WIDTH);

  typedef logic [SPI_WIDTH-1:0] spi_byte_t;

  // A same-cycle txReady takes precedence over an older buffered response.
  function automatic spi_byte_t pick_tx_load(
    input logic      tx_now,
    input spi_byte_t tx_val,
    input logic      pend,
    input spi_byte_t rsp_val,
    input logic      first,
    input logic [2*SPI_WIDTH-1:0] probe_val
  );
    spi_byte_t v;
    if (tx_now)      v = tx_val;
    else if (pend)   v = rsp_val;
    else if (first)  v = probe_val[2*SPI_WIDTH-1:SPI_WIDTH];
    else             v = probe_val[SPI_WIDTH-1:0];
    return v;
  endfunction

endpackage

// File: rtl/my_spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, plus rise/fall pulses on the synchronized value.
module spi_sync
  import my_spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o =  q_o & ~prev_q;
  assign fall_o = ~q_o &  prev_q;

endmodule

// File: rtl/my_spi.sv
// Mode-0 SPI slave clocked from sysclk: receives MSB-first bytes on MOSI and answers with a
// buffered response byte or the probe word on MISO.
module my_spi
  import my_spi_pkg::*;
(
  input  logic                   sysclk,
  input  logic                   rst_n,
  input  logic                   iSPIClk,
  input  logic                   iSPICS,
  input  logic                   iSPIMOSI,
  output logic                   oSPIMISO,
  output logic [SPI_WIDTH-1:0]   oRx,
  output logic                   oRxReady,
  input  logic [SPI_WIDTH-1:0]   tx,
  input  logic                   txReady,
  input  logic [2*SPI_WIDTH-1:0] probe
);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clk_i (sysclk), .rst_n_i (rst_n), .d_i (iSPIClk),
    .q_o (sck_s), .rise_o (sck_rise), .fall_o (sck_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk_i (sysclk), .rst_n_i (rst_n), .d_i (iSPICS),
    .q_o (cs_s), .rise_o (cs_rise), .fall_o (cs_fall)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk_i (sysclk), .rst_n_i (rst_n), .d_i (iSPIMOSI),
    .q_o (mosi_s), .rise_o (mosi_rise), .fall_o (mosi_fall)
  );

  assign unused_sync = ^{sck_s, mosi_rise, mosi_fall};

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  spi_byte_t        rx_sh_q, rx_sh_d;
  spi_byte_t        rx_q, rx_d;
  logic             rx_vld_q, rx_vld_d;
  spi_byte_t        tx_sh_q, tx_sh_d;
  spi_byte_t        rsp_q, rsp_d;
  logic             pend_q, pend_d;
  logic             byte_done;
  logic             byte_start;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_d       = rx_q;
    rx_vld_d   = 1'b0;
    tx_sh_d    = tx_sh_q;
    rsp_d      = rsp_q;
    pend_d     = pend_q;
    byte_done  = 1'b0;
    byte_start = 1'b0;

    if (!cs_s && sck_rise) begin
      rx_sh_d   = {rx_sh_q[SPI_WIDTH-2:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (bit_cnt_q == CNT_W'(SPI_WIDTH - 1)) begin
        rx_d      = rx_sh_d;
        rx_vld_d  = 1'b1;
        byte_done = 1'b1;
      end
    end else if (!cs_s && sck_fall && bit_cnt_q != '0) begin
      // The fall right after a byte completes must not shift out the freshly loaded MSB.
      tx_sh_d = {tx_sh_q[SPI_WIDTH-2:0], 1'b0};
    end

    if (cs_rise || cs_fall) begin
      bit_cnt_d = '0;
      rx_sh_d   = '0;
    end

    if (txReady) begin
      rsp_d  = tx;
      pend_d = 1'b1;
    end

    byte_start = cs_fall || byte_done;
    if (byte_start) begin
      tx_sh_d = pick_tx_load(txReady, tx, pend_q, rsp_q, cs_fall, probe);
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      rx_sh_q   <= '0;
      rx_q      <= '0;
      rx_vld_q  <= 1'b0;
      tx_sh_q   <= '0;
      rsp_q     <= '0;
      pend_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rx_sh_q   <= rx_sh_d;
      rx_q      <= rx_d;
      rx_vld_q  <= rx_vld_d;
      tx_sh_q   <= tx_sh_d;
      rsp_q     <= rsp_d;
      pend_q    <= pend_d;
    end
  end

  assign oRx      = rx_q;
  assign oRxReady = rx_vld_q;
  assign oSPIMISO = tx_sh_q[SPI_WIDTH-1] & ~cs_s;

endmodule

// File: tb/tb_my_spi.sv
// Randomized and directed bench for my_spi against a byte-level model of the response rules.
module tb_my_spi;

  localparam int HALF = 8;

  logic        sysclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iSPIClk = 1'b0;
  logic        iSPICS = 1'b1;
  logic        iSPIMOSI = 1'b0;
  logic        oSPIMISO;
  logic [7:0]  oRx;
  logic        oRxReady;
  logic [7:0]  tx = 8'h00;
  logic        txReady = 1'b0;
  logic [15:0] probe = 16'h0000;

  my_spi dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .iSPIClk  (iSPIClk),
    .iSPICS   (iSPICS),
    .iSPIMOSI (iSPIMOSI),
    .oSPIMISO (oSPIMISO),
    .oRx      (oRx),
    .oRxReady (oRxReady),
    .tx       (tx),
    .txReady  (txReady),
    .probe    (probe)
  );

  always #5 sysclk = ~sysclk;

  int         tests = 0;
  int         fails = 0;
  int         rdy_cnt = 0;
  int         wide_cnt = 0;
  int         exp_rdy = 0;
  logic       prev_rdy = 1'b0;
  logic [7:0] rx_log[$];
  logic [7:0] exp_rx[$];
  logic       m_pend = 1'b0;
  logic [7:0] m_rsp = 8'h00;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] fb[4];

  always @(negedge sysclk) begin
    if (oRxReady) begin
      rdy_cnt <= rdy_cnt + 1;
      rx_log.push_back(oRx);
    end
    if (oRxReady && prev_rdy) wide_cnt <= wide_cnt + 1;
    prev_rdy <= oRxReady;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Byte-start rule: a pending response wins, else the probe half chosen by position in frame.
  task automatic model_load(input bit first, output logic [7:0] v);
    if (m_pend) begin
      v = m_rsp;
      m_pend = 1'b0;
    end else begin
      v = first ? probe[15:8] : probe[7:0];
    end
  endtask

  task automatic pulse_tx(input logic [7:0] v);
    tx = v;
    txReady = 1'b1;
    @(posedge sysclk); #1;
    txReady = 1'b0;
    m_rsp = v;
    m_pend = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      iSPIMOSI = b[7-i];
      repeat (HALF) @(posedge sysclk);
      #1;
      got = {got[6:0], oSPIMISO};
      iSPIClk = 1'b1;
      repeat (HALF) @(posedge sysclk);
      #1;
      iSPIClk = 1'b0;
    end
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_rdy_cnt"}, rdy_cnt, exp_rdy);
    chk({tag, "_orx"}, oRx, last_rx);
    while (rx_log.size() > 0 && exp_rx.size() > 0)
      chk({tag, "_rx_byte"}, rx_log.pop_front(), exp_rx.pop_front());
    chk({tag, "_miso_idle"}, oSPIMISO, 1'b0);
  endtask

  task automatic run_frame(input string tag, input int n, input int mid_tx);
    logic [7:0] expm;
    logic [7:0] got;
    iSPICS = 1'b0;
    repeat (10) @(posedge sysclk);
    #1;
    model_load(1'b1, expm);
    for (int k = 0; k < n; k++) begin
      send_bits(fb[k], 8, got);
      chk($sformatf("%s_miso_b%0d", tag, k), got, expm);
      exp_rx.push_back(fb[k]);
      exp_rdy++;
      last_rx = fb[k];
      model_load(1'b0, expm);
      if (k == mid_tx) pulse_tx(8'($urandom));
    end
    repeat (4) @(posedge sysclk);
    #1;
    iSPICS = 1'b1;
    repeat (8) @(posedge sysclk);
    #1;
    check_rx(tag);
  endtask

  initial begin
    logic [7:0] expm;
    logic [7:0] got;
    logic [4:0] got5;
    logic [4:0] exp5;
    int         n;
    int         mid;

    repeat (3) @(posedge sysclk);
    #1;
    chk("reset_orx", oRx, 8'h00);
    chk("reset_ordy", oRxReady, 1'b0);
    chk("reset_miso", oSPIMISO, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge sysclk);
    #1;

    probe = 16'h1234;
    fb[0] = 8'h3C;
    run_frame("single_3c", 1, -1);

    pulse_tx(8'hA5);
    fb[0] = 8'($urandom);
    fb[1] = 8'($urandom);
    run_frame("tx_a5", 2, -1);

    fb[0] = 8'($urandom);
    fb[1] = 8'($urandom);
    run_frame("probe_1234", 2, -1);

    pulse_tx(8'h11);
    pulse_tx(8'hC7);
    fb[0] = 8'h5A;
    run_frame("last_write", 1, -1);

    // Partial byte: CS rises after five bits, nothing must be delivered.
    iSPICS = 1'b0;
    repeat (10) @(posedge sysclk);
    #1;
    model_load(1'b1, expm);
    send_bits(8'hFF, 5, got);
    got5 = got[4:0];
    exp5 = expm[7:3];
    chk("partial_miso", got5, exp5);
    repeat (4) @(posedge sysclk);
    #1;
    iSPICS = 1'b1;
    repeat (8) @(posedge sysclk);
    #1;
    check_rx("partial");

    fb[0] = 8'h01;
    fb[1] = 8'h02;
    run_frame("b2b_0102", 2, -1);

    for (int it = 0; it < 8; it++) begin
      probe = 16'($urandom);
      if ($urandom_range(0, 1) == 1) pulse_tx(8'($urandom));
      n = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) fb[k] = 8'($urandom);
      mid = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      run_frame($sformatf("rand%0d", it), n, mid);
    end

    // Reset in the middle of a byte.
    iSPICS = 1'b0;
    repeat (10) @(posedge sysclk);
    #1;
    send_bits(8'($urandom), 4, got);
    rst_n = 1'b0;
    #1;
    chk("midrst_orx", oRx, 8'h00);
    chk("midrst_ordy", oRxReady, 1'b0);
    chk("midrst_miso", oSPIMISO, 1'b0);
    iSPICS = 1'b1;
    repeat (5) @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    m_pend = 1'b0;
    last_rx = 8'h00;
    repeat (5) @(posedge sysclk);
    #1;
    chk("midrst_rdy_cnt", rdy_cnt, exp_rdy);
    chk("midrst_orx_after", oRx, 8'h00);
    fb[0] = 8'($urandom);
    run_frame("after_rst", 1, -1);

    chk("ordy_single_cycle", wide_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
